imem_fetch_sequencer: RTL
=========================

// Module: imem_fetch_sequencer
// PURPOSE
//  Fetch controller for the 32-bit synchronous instruction memory (registered read, word-indexed address).
//  Owns the PC, drives the memory address and absorbs the memory's 1-cycle read latency.
//  Presents {instr, pc} to decode with a valid/ready handshake and a 1-entry skid buffer.
//  Accepts branch redirects from execute.
// PARAMETERS
//  RESET_PC  32'd0  fetch address after reset
//  PC_STEP   32'd1  PC increment per fetch (memory is word-indexed)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  fetch_en   in   1   1 = issue fetches; 0 = hold PC (no new issues)
//  imem_addr  out  32  address to instruction memory (= fetch_pc register)
//  imem_instr in   32  memory data; valid the cycle after imem_addr was sampled
//  br_taken   in   1   redirect pulse from execute
//  br_target  in   32  redirect address, sampled when br_taken=1
//  if_valid   out  1   instruction slot to decode is valid
//  id_ready   in   1   decode accepts slot this cycle
//  if_instr   out  32  instruction (0 when if_valid=0)
//  if_pc      out  32  address of if_instr (0 when if_valid=0)
//  halted     out  1   fetch halted (HALT_ON_ZERO_EN only; else 0)
// BEHAVIOUR
//  - Registers: fetch_pc, req_v/req_pc (address the memory latched at the last edge), skid_v/skid_instr/skid_pc, state.
//  - Reset (async): fetch_pc=RESET_PC, req_v=0, skid_v=0, state=RUN; so if_valid=0, if_instr=0, if_pc=0, halted=0.
//  - FSM: RUN, HALT. RUN->HALT only by the zero-word rule (macro). HALT->RUN on br_taken. rst -> RUN.
//  - issue = state==RUN && fetch_en && !br_taken && (id_ready || !if_valid_raw), where if_valid_raw = req_v||skid_v.
//  - On issue: fetch_pc<=fetch_pc+PC_STEP (mod 2^32), req_v<=1, req_pc<=fetch_pc. Otherwise req_v<=0.
//  - Latency: first if_valid one cycle after the first post-reset edge with fetch_en=1; throughput 1 instr/cycle.
//  - Output mux: skid_v ? {skid_instr,skid_pc} : {imem_instr,req_pc}; gated to 0 when if_valid=0.
//  - if_valid = if_valid_raw && !br_taken (combinational kill in the redirect cycle).
//  - Skid capture: req_v && !id_ready -> skid<={imem_instr,req_pc}, skid_v<=1 (no issue that cycle).
//  - Skid drain: skid_v && id_ready -> skid_v<=0; issue allowed in the same cycle.
//  - Invariant: req_v && skid_v never both 1. Nothing is skipped, duplicated or reordered under any stall pattern.
//  - Redirect: br_taken -> fetch_pc<=br_target, req_v<=0, skid_v<=0, state<=RUN. Wins over issue, stall and halt.
//  - Next valid pc is br_target, 1 cycle after the redirect edge (given fetch_en=1).
//  - fetch_en=0: no issue; in-flight req/skid still delivered normally.
//  - rst asserted mid-operation: outputs go to reset values immediately and any pending slot is lost.
// CONFIGURATION
//  HALT_ON_ZERO_EN defined:
//   - An accepted slot (if_valid && id_ready) with if_instr==32'h0 and if_pc!=RESET_PC -> state<=HALT, req_v<=0, skid_v<=0.
//   - In HALT: halted=1, no issue, if_valid=0.
//  HALT_ON_ZERO_EN undefined: zero words pass as ordinary instructions; no HALT state; halted tied 0.
// TESTING (memory model: registered read, MEM[i]=32'hA000_0000+i unless stated)
//  1. Reset, fetch_en=1, id_ready=1 -> if_pc 0,1,2,3... on consecutive cycles, if_instr=A000_0000+pc, no gaps.
//  2. id_ready=0 for 3 cycles while if_pc=3 -> if_pc/if_instr stay at 3/A000_0003; after release 4,5 follow, no skip or duplicate.
//  3. br_taken, br_target=20 while if_pc=6 -> if_valid=0 that cycle; next accepted pc 20, then 21; pc 7 never accepted.
//  4. Redirect with skid_v=1 (stall + br_taken, target 40) -> skid discarded; next valid pc=40.
//  5. HALT_ON_ZERO_EN, MEM[15]=0 -> after accepting pc 15, halted=1, if_valid stays 0; br_taken target 1 -> halted=0, pc 1 delivered.
//  6. rst pulsed mid-stream (between edges) -> if_valid=0, imem_addr=RESET_PC immediately; restart delivers pc 0.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: PC owner and fetch front end for a registered-read instruction memory, with a 1-entry skid buffer toward decode.
// Optional macro HALT_ON_ZERO_EN: stop fetching after an accepted all-zero word (not at RESET_PC).
module imem_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
);
    logic [31:0] fetch_pc;
    logic        req_v;
    logic [31:0] req_pc;
    logic        skid_v;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        if_valid_raw;
    logic        run;
    logic        issue;

`ifdef HALT_ON_ZERO_EN
    typedef enum logic {RUN, HALT} state_t;
    state_t state;
    logic   halt_hit;
    assign run      = state == RUN;
    assign halted   = state == HALT;
    assign halt_hit = if_valid && id_ready && if_instr == 32'h0 && if_pc != RESET_PC;
`else
    assign run    = 1'b1;
    assign halted = 1'b0;
`endif

    assign imem_addr    = fetch_pc;
    assign if_valid_raw = req_v || skid_v;
    assign if_valid     = if_valid_raw && !br_taken;
    assign issue        = run && fetch_en && !br_taken && (id_ready || !if_valid_raw);
    assign if_instr     = !if_valid ? 32'h0 : skid_v ? skid_instr : imem_instr;
    assign if_pc        = !if_valid ? 32'h0 : skid_v ? skid_pc : req_pc;

    // PC advance, in-flight request tracking, skid capture/drain; redirect overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            req_v      <= 1'b0;
            req_pc     <= 32'h0;
            skid_v     <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
`ifdef HALT_ON_ZERO_EN
            state      <= RUN;
`endif
        end else if (br_taken) begin
            fetch_pc <= br_target;
            req_v    <= 1'b0;
            skid_v   <= 1'b0;
`ifdef HALT_ON_ZERO_EN
            state    <= RUN;
`endif
        end else begin
            req_v <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                req_pc   <= fetch_pc;
            end
            if (req_v && !id_ready) begin
                skid_v     <= 1'b1;
                skid_instr <= imem_instr;
                skid_pc    <= req_pc;
            end else if (skid_v && id_ready) begin
                skid_v <= 1'b0;
            end
`ifdef HALT_ON_ZERO_EN
            if (halt_hit) begin
                state  <= HALT;
                req_v  <= 1'b0;
                skid_v <= 1'b0;
            end
`endif
        end
    end
endmodule
